// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared definitions for the byte-serialising memory controller:
//   - RegBus / MemAddrBus : data and address widths of the pipeline side
//   - ctrlState_e         : controller states IDLE / XFER / RWAIT / DONE
//   - laneByte()          : picks byte lane k (bits [8k+7:8k]) out of a word
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

  localparam int RegBus     = 32;
  localparam int MemAddrBus = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } ctrlState_e;

  // Little-endian lane select: lane k lives in bits [8k+7:8k].
  function automatic logic [7:0] laneByte(input logic [RegBus-1:0] word,
                                          input logic [1:0]        lane);
    return word[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// mem_ctrl_if
// Request/response bus between the memory-access pipeline stage and the
// memory controller.
//   mem_ce_i   : request valid, held stable while stall_req is high
//   mem_we_i   : 1 = store, 0 = load
//   mem_sel_i  : store byte-lane enables
//   mem_addr_i : byte address (low two bits ignored)
//   mem_data_i : store data, lane-replicated by the requester
//   mem_data_o : loaded word
//   stall_req  : pipeline must hold while high
// Modports: master = pipeline side, slave = controller side.
// ---------------------------------------------------------------------------
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  logic                  mem_ce_i;
  logic                  mem_we_i;
  logic [3:0]            mem_sel_i;
  logic [MemAddrBus-1:0] mem_addr_i;
  logic [RegBus-1:0]     mem_data_i;
  logic [RegBus-1:0]     mem_data_o;
  logic                  stall_req;

  modport master (
    output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    input  mem_data_o, stall_req
  );

  modport slave (
    input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
    output mem_data_o, stall_req
  );

endinterface

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Turns one 32-bit pipeline memory request into four byte accesses on a
// byte-wide synchronous RAM (read data one cycle after the address) and
// stalls the pipeline until the access has completed.
// Ports:
//   clk       : clock, all state changes on the rising edge
//   rst       : synchronous active-high reset
//   bus       : mem_ctrl_if.slave request/response bus
//   ram_addr  : byte address to the RAM, {word base, lane}
//   ram_dout  : byte written to the RAM
//   ram_din   : byte read from the RAM
//   ram_wr    : RAM write strobe for the current byte
// Parameter:
//   RAM_ADDR_W : RAM byte-address width; request address bits above it are
//                dropped.
// ---------------------------------------------------------------------------
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_ctrl_if.slave             bus,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_dout,
  input  logic [7:0]            ram_din,
  output logic                  ram_wr
);

  ctrlState_e              r_state;
  logic [1:0]              r_cnt;
  logic [RAM_ADDR_W-3:0]   r_base;
  logic                    r_we;
  logic [3:0]              r_sel;
  logic [RegBus-1:0]       r_wdata;
  logic [RegBus-1:0]       r_rdBuf;
  logic [RegBus-1:0]       r_memData;
  logic [1:0]              w_prevLane;

  // Read data lags the address by one cycle, so the byte arriving during
  // an XFER cycle belongs to the lane addressed in the previous cycle.
  assign w_prevLane = r_cnt - 2'd1;

  // RAM-side signals are decoded purely from registered state so nothing
  // on the request bus can ripple through to the RAM. The write strobe is
  // additionally gated by reset so an aborted store stops writing at once.
  assign ram_addr = {r_base, r_cnt};
  assign ram_dout = laneByte(r_wdata, r_cnt);
  assign ram_wr   = (r_state == XFER) && r_we && r_sel[r_cnt] && !rst;

  // The pipeline has to freeze the moment it raises a request in IDLE, so
  // stall follows mem_ce_i combinationally there; DONE releases the stall
  // so the pipeline advances on the same edge that returns us to IDLE.
  always_comb begin
    bus.stall_req = 1'b1;
    case (r_state)
      IDLE:    bus.stall_req = bus.mem_ce_i;
      XFER:    bus.stall_req = 1'b1;
      RWAIT:   bus.stall_req = 1'b1;
      DONE:    bus.stall_req = 1'b0;
      default: bus.stall_req = 1'b1;
    endcase
  end

  assign bus.mem_data_o = r_memData;

  // Main controller: latch the request in IDLE, walk the four byte lanes in
  // XFER, collect the last read byte in RWAIT, then spend one DONE cycle
  // handing control back. Loads fill the read buffer one cycle behind the
  // address; the loaded word is published only on the RWAIT->DONE edge so
  // mem_data_o holds steady across stores and idle periods.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 2'd0;
      r_base    <= '0;
      r_we      <= 1'b0;
      r_sel     <= 4'd0;
      r_wdata   <= '0;
      r_rdBuf   <= '0;
      r_memData <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.mem_ce_i) begin
            r_base  <= bus.mem_addr_i[RAM_ADDR_W-1:2];
            r_we    <= bus.mem_we_i;
            r_sel   <= bus.mem_sel_i;
            r_wdata <= bus.mem_data_i;
            r_cnt   <= 2'd0;
            r_state <= XFER;
          end
        end
        XFER: begin
          if (!r_we && (r_cnt != 2'd0)) begin
            r_rdBuf[{w_prevLane, 3'b000} +: 8] <= ram_din;
          end
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_state <= r_we ? DONE : RWAIT;
          end
        end
        RWAIT: begin
          r_rdBuf[31:24] <= ram_din;
          r_memData      <= {ram_din, r_rdBuf[23:0]};
          r_state        <= DONE;
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Downstream of the memory-access pipeline stage; consumes its memory request (ce/we/sel/addr/wdata) and returns the loaded word.
- Serialises each 32-bit request into four byte accesses on a byte-wide synchronous RAM port.
- Holds stall_req high until the access completes, so the pipeline freezes.
- Little-endian: byte lane k is bits [8k+7:8k] and RAM address {word_addr, k}.

Parameters:
RAM_ADDR_W, 17, width of byte address on RAM port; request address bits above this are ignored.

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous, active-high reset
mem_ce_i  in  1  request valid; held stable by pipeline while stall_req=1
mem_we_i  in  1  1=store, 0=load
mem_sel_i  in  4  store byte-lane enables; ignored for loads (load always fetches full word)
mem_addr_i  in  32  byte address; bits [1:0] ignored (word aligned internally)
mem_data_i  in  32  store data, already lane-replicated by requester
mem_data_o  out  32  loaded word
stall_req  out  1  1 = pipeline must hold
ram_addr  out  RAM_ADDR_W  byte address to RAM
ram_dout  out  8  write byte to RAM
ram_din  in  8  read byte from RAM; valid one cycle after address presented
ram_wr  out  1  RAM write strobe for current byte

Behaviour:
- States: IDLE, XFER, RWAIT, DONE; 2-bit cnt; latched base (addr[RAM_ADDR_W-1:2]), we, sel, wdata; 32-bit read buffer.
- Reset (sync, any state incl. mid-transfer): state=IDLE, cnt=0, mem_data_o=0, buffer=0, latches=0; ram_wr=0, ram_addr=0, ram_dout=0. Aborted transfer issues no further ram_wr.
- RAM outputs depend only on internal registers (no comb path from request inputs). stall_req is combinational.
- IDLE: stall_req=mem_ce_i; ram_wr=0. If mem_ce_i: latch request, cnt=0, go XFER.
- XFER: ram_addr={base,cnt}.
  - Store: ram_wr=sel[cnt]; ram_dout=wdata[8cnt+7:8cnt].
  - Load: ram_wr=0. From the second XFER cycle, buffer byte cnt-1 <= ram_din.
  - cnt increments each cycle. At cnt==3: store -> DONE; load -> RWAIT.
  - stall_req=1.
- RWAIT (load only): buffer byte 3 <= ram_din; mem_data_o <= {ram_din, buffer[23:0]} at edge; go DONE; stall_req=1; ram_wr=0.
- DONE: stall_req=0 (pipeline advances this edge); ram_wr=0; go IDLE unconditionally. A request present in DONE is not accepted.
- Latency, stall_req high from the first cycle mem_ce_i is seen in IDLE:
  - Load: 6 cycles stall, DONE in cycle 7.
  - Store: 5 cycles stall, DONE in cycle 6.
  - Back-to-back requests: one IDLE cycle between them (also stalled).
- Store with sel=0000: walks 4 XFER cycles, no ram_wr, completes normally.
- mem_data_o changes only at RWAIT->DONE; it holds across stores and idle.
- Changes to request inputs after latching are ignored until DONE.

Decomposition:
- Put the state encodings (IDLE/XFER/RWAIT/DONE) and reuse of RegBus/MemAddrBus widths in defines.v.
- No sub-module; the byte-lane mux and read buffer are in-line.

Test Plan:
- Reset then idle: mem_ce_i=0 for 5 cycles -> stall_req=0, ram_wr=0, mem_data_o=0.
- Load addr 0x104 with RAM[0x104..0x107]=11,22,33,44 -> ram_addr steps 0x104..0x107, stall high 6 cycles, mem_data_o=0x44332211 in DONE, stall low.
- Store addr 0x203, data 0xAABBCCDD, sel=0100 -> single ram_wr at ram_addr 0x202 with ram_dout=0xBB; other RAM bytes unchanged; stall 5 cycles.
- Store sel=1111 then immediate load of same word -> load returns 0xAABBCCDD; one IDLE stall cycle between the two requests.
- Reset asserted during third XFER cycle of store sel=1111 -> only the first two bytes written, state IDLE next cycle, stall_req follows mem_ce_i.
- Address bit above RAM_ADDR_W set (0x80020000) -> ram_addr=0x00000 range; requester inputs changed mid-transfer have no effect on ram_addr/ram_dout.
